// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared state encoding and direction constants for the count sequencer
package count_seq_pkg;

    // Sequencer phases: waiting for a command, stepping, one-cycle completion
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Direction encoding shared by the command field and the step counter
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/seq_step_counter.sv
// rtl/seq_step_counter.sv - WIDTH-bit wrap-around up/down counter with load, enable and direction
module seq_step_counter
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority over stepping; WIDTH-bit arithmetic provides the wrap
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (dir_i == DIR_DOWN) begin
                count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - command-driven burst sequencer for the wrap counter; optional COUNT_SEQ_HOLD_EN adds a hold input
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
`ifdef COUNT_SEQ_HOLD_EN
    input  logic             hold,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_dir,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             step_en,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [LEN_W-1:0] remaining_q;
    logic [LEN_W-1:0] remaining_d;
    logic             dir_q;
    logic             dir_d;
    logic             aborted_q;
    logic             aborted_d;

    logic             hold_w;
    logic             accept;
    logic             advance;
    logic             in_run;

`ifdef COUNT_SEQ_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign in_run  = (state_q == RUN);
    assign accept  = cmd_valid && (state_q == IDLE);
    // Abort wins over both hold and the final step: no movement on that edge
    assign advance = in_run && !abort && !hold_w;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: zero-length jobs skip RUN; the last step or an abort lands in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (cmd_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = DONE;
                end else if (!hold_w && (remaining_q == LEN_ONE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from the current state (plus hold for step_en)
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        step_en   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            RUN: begin
                busy    = 1'b1;
                step_en = !hold_w;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Job bookkeeping: steps left, latched direction, abort flag
    always_comb begin
        remaining_d = remaining_q;
        dir_d       = dir_q;
        aborted_d   = aborted_q;
        if (accept) begin
            remaining_d = cmd_len;
            dir_d       = cmd_dir;
            aborted_d   = 1'b0;
        end else if (in_run && abort) begin
            aborted_d = 1'b1;
        end else if (advance) begin
            remaining_d = remaining_q - LEN_ONE;
        end
    end

    // Job bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_q <= '0;
            dir_q       <= DIR_UP;
            aborted_q   <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            aborted_q   <= aborted_d;
        end
    end

    assign aborted = aborted_q;

    seq_step_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (cmd_start),
        .en_i       (advance),
        .dir_i      (dir_q),
        .count_o    (count)
    );

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - self-checking bench for count_sequencer against a cycle-indexed job model
module tb_count_sequencer;

    localparam int WIDTH = 2;
    localparam int LEN_W = 8;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_dir;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             step_en;
    logic             busy;
    logic             done;
    logic             aborted;
`ifdef COUNT_SEQ_HOLD_EN
    logic             hold = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    count_sequencer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef COUNT_SEQ_HOLD_EN
        .hold      (hold),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .cmd_dir   (cmd_dir),
        .abort     (abort),
        .count     (count),
        .step_en   (step_en),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    function automatic int wrap_pos(input int start, input int dir, input int k);
        int v;
        v = (dir != 0) ? start - k : start + k;
        return ((v % MOD) + MOD) % MOD;
    endfunction

    // Runs one job from an IDLE negedge sample point; abort_at is the cycle index
    // (0 = cycle right after accept) in which abort is held, or -1 for none.
    // Returns at the negedge of the IDLE cycle that follows the job.
    task automatic run_job(input string name, input int start, input int len,
                           input int dir, input int abort_at);
        int last;
        int eff;
        int st;          // 0 idle, 1 run, 2 done
        int exp_ab;
        int done_hits;
        done_hits = 0;
        last = (abort_at >= 0) ? abort_at + 2 : len + 1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %0b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_start = WIDTH'(start);
        cmd_len   = LEN_W'(len);
        cmd_dir   = dir[0];
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            // Commands offered while busy must be ignored
            if (c < last - 1) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_start = WIDTH'($urandom);
                cmd_len   = LEN_W'($urandom);
                cmd_dir   = 1'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            // Stray abort in DONE must be ignored
            abort = (c == abort_at) || ((c == last - 1) && ($urandom_range(0, 1) == 1));
            @(negedge clk);
            if (abort_at >= 0) begin
                eff    = (c < abort_at) ? c : abort_at;
                st     = (c <= abort_at) ? 1 : ((c == abort_at + 1) ? 2 : 0);
                exp_ab = (c > abort_at) ? 1 : 0;
            end else begin
                eff    = (c < len) ? c : len;
                st     = (c < len) ? 1 : ((c == len) ? 2 : 0);
                exp_ab = 0;
            end
            if (done === 1'b1) done_hits++;
            checks++;
            if (count !== WIDTH'(wrap_pos(start, dir, eff))) begin
                errors++;
                $display("FAIL %s count c=%0d got %0d want %0d", name, c, count, wrap_pos(start, dir, eff));
            end
            checks++;
            if (done !== (st == 2)) begin
                errors++;
                $display("FAIL %s done c=%0d got %0b want %0b", name, c, done, (st == 2));
            end
            checks++;
            if (busy !== (st != 0)) begin
                errors++;
                $display("FAIL %s busy c=%0d got %0b want %0b", name, c, busy, (st != 0));
            end
            checks++;
            if (cmd_ready !== (st == 0)) begin
                errors++;
                $display("FAIL %s cmd_ready c=%0d got %0b want %0b", name, c, cmd_ready, (st == 0));
            end
            checks++;
            if (step_en !== (st == 1)) begin
                errors++;
                $display("FAIL %s step_en c=%0d got %0b want %0b", name, c, step_en, (st == 1));
            end
            checks++;
            if (aborted !== exp_ab[0]) begin
                errors++;
                $display("FAIL %s aborted c=%0d got %0b want %0b", name, c, aborted, exp_ab[0]);
            end
        end
        abort = 1'b0;
        checks++;
        if (done_hits != 1) begin
            errors++;
            $display("FAIL %s done_pulses got %0d want 1", name, done_hits);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_len   = '0;
        cmd_dir   = 1'b0;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // Load a nonzero count, then reset in the middle of a cycle
        cmd_valid = 1'b1;
        cmd_start = 2'd3;
        cmd_len   = 8'd5;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({count, busy, done, aborted, cmd_ready, step_en} !== {2'd0, 5'b00010}) begin
            errors++;
            $display("FAIL reset_async got count=%0d busy=%0b done=%0b aborted=%0b ready=%0b step=%0b want 0 0 0 0 1 0",
                     count, busy, done, aborted, cmd_ready, step_en);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int done_hits;
        done_hits = 0;
        cmd_valid = 1'b1;
        cmd_start = 2'd1;
        cmd_len   = 8'd8;
        cmd_dir   = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (count !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run got count=%0d busy=%0b want 0 0", count, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_hits++;
        end
        checks++;
        if (done_hits != 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d pulses want 0", done_hits);
        end
        run_job("after_reset", 1, 1, 0, -1);
    endtask

    task automatic test_random();
        int s;
        int l;
        int d;
        int a;
        for (int j = 0; j < 30; j++) begin
            s = int'($urandom_range(0, MOD - 1));
            l = int'($urandom_range(0, 12));
            d = int'($urandom_range(0, 1));
            a = (l > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, l - 1)) : -1;
            run_job("random", s, l, d, a);
        end
    endtask

    initial begin
        test_reset();
        run_job("up_wrap", 2, 5, 0, -1);
        run_job("down_wrap", 1, 3, 1, -1);
        run_job("zero_len", 3, 0, 0, -1);
        run_job("abort", 0, 10, 0, 2);
        run_job("abort_last_step", 1, 4, 1, 3);
        run_job("clears_aborted", 2, 2, 0, -1);
        run_job("max_len", 3, 255, 1, -1);
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

endmodule
